uart_tx_scheduler: RTL and testbench

Shares one `uart_transmitter` between `NUM_REQ` byte-stream requesters with round-robin, message-granular arbitration. A grant is held until the requester's last byte is accepted, so messages never interleave on the serial line. The block also owns the transmitter's `baud_edge` setting and applies divisor changes only at message boundaries with the line idle. It sits between the on-chip UART clients (console, debug, MMIO bridge) and the transmitter.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/rr_pick.sv | 37 +++
 rtl/uart_tx_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit scheduler
package uart_pkg;

    // Scheduler FSM: IDLE arbitrates and applies divisor changes, LOCK forwards one message.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } sched_state_e;

    localparam int MIN_NUM_REQ = 2;
    localparam int MAX_NUM_REQ = 8;

    // Divisor loaded into baud_edge out of reset.
    function automatic int calc_baud_edge(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    function automatic bit num_req_ok(input int n);
        return (n >= MIN_NUM_REQ) && (n <= MAX_NUM_REQ);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin first-set search
//
// Ports:
//   req_valid_i  request bit per requester
//   rr_ptr_i     index searched first; search wraps past NUM_REQ-1 to 0
//   index_o      first requester with its bit set at or after rr_ptr_i
//   any_o        at least one request bit is set
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [IDX_W-1:0]   index_o,
    output logic               any_o
);

    int cand;

    // Walk offsets from farthest to nearest so the nearest set bit is the last writer.
    always_comb begin
        index_o = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = int'(rr_ptr_i) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (req_valid_i[cand]) begin
                index_o = IDX_W'(cand);
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - message-granular round-robin sharing of one UART transmitter
//
// Optional feature macro: UART_TX_SCHED_TIMEOUT_EN (forced lock release after a stall).
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   req_data          byte per requester, requester i at [8i+:8]
//   req_valid         byte valid per requester
//   req_last          byte is the final byte of its message
//   req_ready         byte accepted when valid & ready (only the lock owner)
//   tx_data/tx_valid  byte stream to the transmitter
//   tx_ready          transmitter can accept a byte
//   baud_edge         divisor driven to the transmitter
//   cfg_baud_edge     new divisor value, cfg_baud_we one-cycle write strobe
//   cfg_pending       a divisor write waits to be applied
//   grant_id          current lock owner, valid while busy
//   busy              a requester holds the lock
//   timeout           one-cycle pulse on forced lock release
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter  int CLOCK_FREQ     = 125_000_000,
    parameter  int BAUD_RATE      = 115_200,
    parameter  int MIN_BDRT       = 9_600,
    parameter  int BAUD_BITS      = $clog2((CLOCK_FREQ + (MIN_BDRT / 2) - 1) / (MIN_BDRT / 2)),
    parameter  int NUM_REQ        = 4,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ*8-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [BAUD_BITS-1:0]   baud_edge,
    input  logic [BAUD_BITS-1:0]   cfg_baud_edge,
    input  logic                   cfg_baud_we,
    output logic                   cfg_pending,
    output logic [IDX_W-1:0]       grant_id,
    output logic                   busy,
    output logic                   timeout
);

    localparam int                   DEFAULT_BAUD_EDGE = calc_baud_edge(CLOCK_FREQ, BAUD_RATE);
    localparam logic [BAUD_BITS-1:0] BAUD_RESET        = BAUD_BITS'(DEFAULT_BAUD_EDGE);

    if (!num_req_ok(NUM_REQ)) begin : g_num_req_check
        $error("uart_tx_scheduler: NUM_REQ must be 2..8");
    end

    sched_state_e         state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BAUD_BITS-1:0] shadow_q, shadow_d;
    logic [BAUD_BITS-1:0] baud_q, baud_d;
    logic                 pending_q, pending_d;

    logic [7:0]           req_bytes [NUM_REQ];
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic [IDX_W-1:0]     rr_next;
    logic                 handshake;
    logic                 msg_done;
    logic                 force_release;
    logic                 cfg_write;
    logic                 cfg_apply;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_bytes[g] = req_data[8*g +: 8];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .index_o     (pick_idx),
        .any_o       (pick_any)
    );

    // Forwarding is purely combinational: the transmitter's ready drop after each
    // accept is seen directly by the owner, so no byte is ever held in a register here.
    always_comb begin
        req_ready = '0;
        tx_data   = '0;
        tx_valid  = 1'b0;
        if (state_q == ST_LOCK) begin
            tx_data             = req_bytes[grant_q];
            tx_valid            = req_valid[grant_q];
            req_ready[grant_q]  = tx_ready;
        end
    end

    assign handshake = tx_valid & tx_ready;
    assign msg_done  = handshake & req_last[grant_q];
    assign rr_next   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] stall_cnt_q, stall_cnt_d;
    logic            stalled;

    assign stalled       = (state_q == ST_LOCK) && !req_valid[grant_q];
    // Release on the stall cycle that brings the count to TIMEOUT_CYCLES.
    assign force_release = stalled && (stall_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign timeout       = force_release;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q != ST_LOCK) || handshake || force_release) begin
            stall_cnt_d = '0;
        end else if (stalled) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign force_release      = 1'b0;
    assign timeout            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                // A queued divisor change must land before the next message starts.
                if (!pending_q && pick_any) begin
                    grant_d = pick_idx;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (msg_done || force_release) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = rr_next;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A fresh write in the apply cycle wins: it replaces the shadow and keeps the
    // change pending, so the older value never reaches the line.
    assign cfg_write = cfg_baud_we && (cfg_baud_edge != '0);
    assign cfg_apply = (state_q == ST_IDLE) && pending_q && tx_ready && !cfg_write;

    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        baud_d    = baud_q;
        if (cfg_write) begin
            shadow_d  = cfg_baud_edge;
            pending_d = 1'b1;
        end else if (cfg_apply) begin
            baud_d    = shadow_q;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            shadow_q  <= BAUD_RESET;
            baud_q    <= BAUD_RESET;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            shadow_q  <= shadow_d;
            baud_q    <= baud_d;
            pending_q <= pending_d;
        end
    end

    assign busy        = (state_q == ST_LOCK);
    assign grant_id    = grant_q;
    assign baud_edge   = baud_q;
    assign cfg_pending = pending_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

    localparam int NR = 4;
    localparam int BB = $clog2((125_000_000 + (9_600 / 2) - 1) / (9_600 / 2));
    localparam int TO = 16;
    localparam logic [BB-1:0] BAUD_DEF = BB'(125_000_000 / 115_200);

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [NR*8-1:0] req_data = '0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_last = '0;
    logic [NR-1:0]   req_ready;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready = 1'b0;
    logic [BB-1:0]   baud_edge;
    logic [BB-1:0]   cfg_baud_edge = '0;
    logic            cfg_baud_we = 1'b0;
    logic            cfg_pending;
    logic [1:0]      grant_id;
    logic            busy;
    logic            timeout;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .baud_edge     (baud_edge),
        .cfg_baud_edge (cfg_baud_edge),
        .cfg_baud_we   (cfg_baud_we),
        .cfg_pending   (cfg_pending),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout       (timeout)
    );

    typedef struct {
        logic          we;
        logic [BB-1:0] val;
        logic          rdy;
        logic          exp_pend;
        logic [BB-1:0] exp_baud;
    } cfg_vec_t;

    int errors = 0;
    int checks = 0;

    logic [8:0]  rq [NR][$];
    logic [11:0] sb [$];

    int            txmode = 0;
    logic          prev_hs = 1'b0;
    logic          cfg_we_n = 1'b0;
    logic [BB-1:0] cfg_val_n = '0;
    int            cyc = 0;
    int            timeout_seen = 0;
    int            timeout_cyc = -1;

    logic          s_busy = 1'b0;
    logic [1:0]    s_grant;
    logic          s_hs;
    logic          s_hs_last;
    logic          s_pending;
    logic [BB-1:0] s_baud;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input int id, input int n, input logic [7:0] base);
        logic [7:0] b;
        logic       l;
        for (int j = 0; j < n; j++) begin
            b = base + 8'(j);
            l = (j == n - 1);
            rq[id].push_back({l, b});
            sb.push_back({3'(id), l, b});
        end
    endtask

    // One clock: drive at negedge, sample #1 later, score any handshake, then pass posedge.
    task automatic run_cycle();
        logic [11:0] e;
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = rq[i][0][7:0];
                req_last[i]        = rq[i][0][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
        case (txmode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = !prev_hs;
            default: tx_ready = 1'b0;
        endcase
        cfg_baud_we   = cfg_we_n;
        cfg_baud_edge = cfg_val_n;
        #1;
        s_busy    = busy;
        s_grant   = grant_id;
        s_pending = cfg_pending;
        s_baud    = baud_edge;
        s_hs      = tx_valid && tx_ready;
        s_hs_last = 1'b0;
        if (timeout) begin
            timeout_seen++;
            if (timeout_cyc < 0) timeout_cyc = cyc;
        end
        if (s_hs) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_byte: got %0d expected none", tx_data);
            end else begin
                e = sb.pop_front();
                s_hs_last = e[8];
                chk("hs_grant", 32'(grant_id), 32'(e[11:9]));
                chk("hs_byte", 32'(tx_data), 32'(e[7:0]));
                chk("hs_ready_onehot", 32'(req_ready), 32'(4'b0001 << e[11:9]));
            end
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) void'(rq[i].pop_front());
            end
        end
        prev_hs = s_hs;
        @(posedge clk);
        cfg_we_n = 1'b0;
        cyc++;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((sb.size() > 0 || s_busy) && n < maxc) begin
            run_cycle();
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        req_valid = '0;
        for (int i = 0; i < NR; i++) rq[i].delete();
        sb.delete();
        prev_hs = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        s_busy  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cfg_vec_t tbl [10];
        int       t0, t1, base;
        logic     busy_h [64];

        tbl[0] = '{1'b1, BB'(0),    1'b0, 1'b0, BB'(1085)};
        tbl[1] = '{1'b1, BB'(300),  1'b0, 1'b1, BB'(1085)};
        tbl[2] = '{1'b1, BB'(400),  1'b0, 1'b1, BB'(1085)};
        tbl[3] = '{1'b0, BB'(0),    1'b1, 1'b0, BB'(400)};
        tbl[4] = '{1'b1, BB'(500),  1'b1, 1'b1, BB'(400)};
        tbl[5] = '{1'b1, BB'(600),  1'b1, 1'b1, BB'(400)};
        tbl[6] = '{1'b0, BB'(0),    1'b1, 1'b0, BB'(600)};
        tbl[7] = '{1'b1, BB'(0),    1'b1, 1'b0, BB'(600)};
        tbl[8] = '{1'b1, BB'(1085), 1'b1, 1'b1, BB'(600)};
        tbl[9] = '{1'b0, BB'(0),    1'b1, 1'b0, BB'(1085)};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_pending", 32'(cfg_pending), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_baud", 32'(baud_edge), 32'(BAUD_DEF));

        // Divisor write/apply vectors, all in IDLE
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cfg_baud_we   = tbl[i].we;
            cfg_baud_edge = tbl[i].val;
            tx_ready      = tbl[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("cfg_pending[%0d]", i), 32'(cfg_pending), 32'(tbl[i].exp_pend));
            chk($sformatf("cfg_baud[%0d]", i), 32'(baud_edge), 32'(tbl[i].exp_baud));
        end
        @(negedge clk);
        cfg_baud_we = 1'b0;

        // Requester 2 alone, 3 bytes, tx_ready tied 1
        txmode = 0;
        send(2, 3, 8'h20);
        run_cycle();
        chk("c_latency_busy0", 32'(s_busy), 32'd0);
        run_cycle();
        chk("c_busy1", 32'(s_busy), 32'd1);
        chk("c_grant2", 32'(s_grant), 32'd2);
        run_cycle();
        run_cycle();
        run_cycle();
        chk("c_busy_drop", 32'(s_busy), 32'd0);
        // rr_ptr is now 3: requester 3 goes before 0
        send(3, 1, 8'h30);
        send(0, 1, 8'h38);
        drain(20);

        // Requesters 0 and 1 from reset, transmitter drops ready after each accept
        do_reset();
        txmode = 1;
        send(0, 2, 8'h40);
        send(1, 2, 8'h50);
        t0 = -1;
        t1 = -1;
        for (int k = 0; k < 40; k++) begin
            run_cycle();
            busy_h[k] = s_busy;
            if (s_hs && s_grant == 2'd0 && s_hs_last) t0 = k;
            if (s_busy && s_grant == 2'd1 && t1 < 0) t1 = k;
            if (sb.size() == 0 && !s_busy) break;
        end
        chk("d_gap_cycles", 32'(t1 - t0), 32'd2);
        if (t0 >= 0 && t0 < 63) chk("d_gap_idle", 32'(busy_h[t0 + 1]), 32'd0);
        else chk("d_last_hs_found", 32'(t0), 32'd3);
        chk("d_drain_left", 32'(sb.size()), 32'd0);

        // Divisor write during a message; a waiting request is held off until the apply
        txmode = 0;
        send(2, 3, 8'h60);
        send(0, 1, 8'h70);
        run_cycle();
        cfg_we_n  = 1'b1;
        cfg_val_n = BB'(217);
        run_cycle();
        chk("e_grant2", 32'(s_grant), 32'd2);
        run_cycle();
        chk("e_pending_in_msg", 32'(s_pending), 32'd1);
        chk("e_baud_in_msg", 32'(s_baud), 32'(BAUD_DEF));
        run_cycle();
        txmode = 2;
        repeat (3) run_cycle();
        chk("e_blocked_busy", 32'(s_busy), 32'd0);
        chk("e_blocked_pending", 32'(s_pending), 32'd1);
        chk("e_blocked_baud", 32'(s_baud), 32'(BAUD_DEF));
        txmode = 0;
        run_cycle();
        run_cycle();
        chk("e_applied_baud", 32'(s_baud), 32'd217);
        chk("e_applied_pending", 32'(s_pending), 32'd0);
        chk("e_applied_busy", 32'(s_busy), 32'd0);
        drain(10);

`ifdef UART_TX_SCHED_TIMEOUT_EN
        // Requester 1 stalls after one byte; requester 3 waits
        rq[1].push_back({1'b0, 8'h80});
        sb.push_back({3'd1, 1'b0, 8'h80});
        send(3, 1, 8'h90);
        base = cyc;
        drain(60);
        chk("to_pulse_cycle", 32'(timeout_cyc - base), 32'd17);
        chk("to_pulse_count", 32'(timeout_seen), 32'd1);
`else
        base = cyc;
        chk("to_never", 32'(timeout_seen), 32'd0);
`endif

        // Asynchronous reset in the middle of a message, with a divisor write pending
        send(1, 3, 8'hA0);
        cfg_we_n  = 1'b1;
        cfg_val_n = BB'(300);
        run_cycle();
        run_cycle();
        @(negedge clk);
        #1;
        chk("g_busy_before", 32'(busy), 32'd1);
        chk("g_pending_before", 32'(cfg_pending), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("g_busy", 32'(busy), 32'd0);
        chk("g_tx_valid", 32'(tx_valid), 32'd0);
        chk("g_tx_data", 32'(tx_data), 32'd0);
        chk("g_req_ready", 32'(req_ready), 32'd0);
        chk("g_grant", 32'(grant_id), 32'd0);
        chk("g_pending", 32'(cfg_pending), 32'd0);
        chk("g_timeout", 32'(timeout), 32'd0);
        chk("g_baud", 32'(baud_edge), 32'd1085);
        req_valid = '0;
        for (int i = 0; i < NR; i++) rq[i].delete();
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("g_after_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
